// File: rtl/acc_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_alu_if : control/data bundle between datapath controller and acc_alu    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface acc_alu_if #(
  parameter int N  = 4,
  parameter int CH = 2
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

  logic             clear;
  logic             en;
  logic [2:0]       op;
  logic [SEL_W-1:0] sel;
  logic [CH*N-1:0]  din;
  logic [N-1:0]     Z;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (output clear, en, op, sel, din, input  Z, carry, ovf, zero);
  modport slave  (input  clear, en, op, sel, din, output Z, carry, ovf, zero);
endinterface
`default_nettype wire

// File: rtl/acc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_alu : channel-selecting accumulator with registered ALU ops and flags   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module acc_alu #(
  parameter int N   = 4,
  parameter int CH  = 2,
  parameter int SAT = 0
) (
  input  logic     clk,
  input  logic     reset,
  acc_alu_if.slave bus
);
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;
  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] z_q, z_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;
  logic [N-1:0] w_d_sel;
  logic [N-1:0] w_opnd;
  logic [N:0]   w_sum;
  logic [N:0]   w_diff;

  // Out-of-range selects fall through to zero because no channel matches.
  always_comb begin
    w_d_sel = '0;
    for (int k = 0; k < CH; k++) begin
      if (int'(bus.sel) == k) w_d_sel = bus.din[k*N +: N];
    end
  end

  // INC/DEC reuse the ADD/SUB path with a constant 1, so flags share one rule.
  always_comb begin
    w_opnd = ((bus.op == OP_INC) || (bus.op == OP_DEC)) ? C_ONE : w_d_sel;
    w_sum  = {1'b0, z_q} + {1'b0, w_opnd};
    w_diff = {1'b0, z_q} - {1'b0, w_opnd};
  end

  always_comb begin
    z_d     = z_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      z_d     = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (bus.en) begin
      case (bus.op)
        OP_LOAD: begin
          z_d     = w_d_sel;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_INC, OP_ADD: begin
          z_d     = w_sum[N-1:0];
          carry_d = w_sum[N];
          ovf_d   = (z_q[N-1] == w_opnd[N-1]) && (w_sum[N-1] != z_q[N-1]);
          if ((SAT != 0) && w_sum[N]) z_d = '1;
        end
        OP_DEC, OP_SUB: begin
          z_d     = w_diff[N-1:0];
          carry_d = w_diff[N];
          ovf_d   = (z_q[N-1] != w_opnd[N-1]) && (w_diff[N-1] != z_q[N-1]);
          if ((SAT != 0) && w_diff[N]) z_d = '0;
        end
        OP_SHL: begin
          z_d     = {z_q[N-2:0], 1'b0};
          carry_d = z_q[N-1];
          ovf_d   = 1'b0;
        end
        OP_SHR: begin
          z_d     = {1'b0, z_q[N-1:1]};
          carry_d = z_q[0];
          ovf_d   = 1'b0;
        end
        default: begin
          z_d     = z_q;
          carry_d = carry_q;
          ovf_d   = ovf_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      z_q     <= z_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Z     = z_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = (z_q == '0);
endmodule
`default_nettype wire

// File: tb/tb_acc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acc_alu : directed vectors for wrap, saturating, wide and 3-channel ALUs |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_acc_alu;
  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011;
  localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, SHL = 3'b110, SHR = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  acc_alu_if #(.N(4), .CH(2)) b0 ();
  acc_alu_if #(.N(4), .CH(2)) b1 ();
  acc_alu_if #(.N(8), .CH(4)) b2 ();
  acc_alu_if #(.N(4), .CH(3)) b3 ();

  acc_alu #(.N(4), .CH(2), .SAT(0)) u_wrap (.clk(clk), .reset(reset), .bus(b0.slave));
  acc_alu #(.N(4), .CH(2), .SAT(1)) u_sat  (.clk(clk), .reset(reset), .bus(b1.slave));
  acc_alu #(.N(8), .CH(4), .SAT(0)) u_wide (.clk(clk), .reset(reset), .bus(b2.slave));
  acc_alu #(.N(4), .CH(3), .SAT(0)) u_ch3  (.clk(clk), .reset(reset), .bus(b3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic clr, input logic e, input logic [2:0] o,
                      input logic s, input logic [7:0] d);
    b0.clear = clr; b0.en = e; b0.op = o; b0.sel = s; b0.din = d;
  endtask

  task automatic drv1(input logic [2:0] o, input logic [3:0] d);
    b1.clear = 1'b0; b1.en = 1'b1; b1.op = o; b1.sel = 1'b0; b1.din = {4'h0, d};
  endtask

  initial begin
    reset = 1'b1;
    drv0(0, 0, NOP, 0, 8'h00);
    b1.clear = 0; b1.en = 0; b1.op = NOP; b1.sel = 0; b1.din = '0;
    b2.clear = 0; b2.en = 0; b2.op = NOP; b2.sel = 0; b2.din = '0;
    b3.clear = 0; b3.en = 0; b3.op = NOP; b3.sel = 0; b3.din = '0;
    #12;
    chk("rst_z", b0.Z, 0);
    chk("rst_zero", b0.zero, 1);
    reset = 1'b0;

    // Async reset mid-run, then clear beats a pending LOAD
    drv0(0, 1, LOAD, 0, 8'h0A); tick();
    chk("load_1010", b0.Z, 4'b1010);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_z", b0.Z, 0);
    chk("async_rst_flags", {b0.carry, b0.ovf, b0.zero}, 3'b001);
    reset = 1'b0;
    drv0(1, 1, LOAD, 0, 8'h05); tick();
    chk("clear_wins", b0.Z, 0);

    // Channel select and hold
    drv0(0, 1, LOAD, 1, 8'hC3); tick();
    chk("load_ch1", b0.Z, 4'b1100);
    drv0(0, 1, LOAD, 0, 8'hC3); tick();
    chk("load_ch0", b0.Z, 4'b0011);
    drv0(0, 0, INC, 0, 8'hC3); tick(); tick(); tick();
    chk("en_low_hold", b0.Z, 4'b0011);

    // Wrap counting
    drv0(0, 1, LOAD, 0, 8'h0E); tick();
    drv0(0, 1, INC, 0, 8'h0E); tick();
    chk("inc_1111", {b0.Z, b0.carry}, {4'b1111, 1'b0});
    tick();
    chk("inc_wrap", {b0.Z, b0.carry, b0.zero}, {4'b0000, 1'b1, 1'b1});
    drv0(0, 1, DEC, 0, 8'h00); tick();
    chk("dec_wrap", {b0.Z, b0.carry}, {4'b1111, 1'b1});
    tick();
    chk("dec_1110", {b0.Z, b0.carry}, {4'b1110, 1'b0});

    // Add/sub flags
    drv0(0, 1, LOAD, 0, 8'h07); tick();
    drv0(0, 1, ADD, 0, 8'h01); tick();
    chk("add_ovf", {b0.Z, b0.carry, b0.ovf}, {4'b1000, 1'b0, 1'b1});
    drv0(0, 1, SUB, 0, 8'h09); tick();
    chk("sub_borrow", {b0.Z, b0.carry, b0.ovf}, {4'b1111, 1'b1, 1'b0});
    drv0(0, 1, NOP, 0, 8'h09); tick();
    chk("nop_hold", {b0.Z, b0.carry}, {4'b1111, 1'b1});
    drv0(0, 1, SUB, 0, 8'h0F); tick();
    chk("sub_zero", {b0.Z, b0.carry, b0.zero}, {4'b0000, 1'b0, 1'b1});
    drv0(0, 1, LOAD, 0, 8'h08); tick();
    drv0(0, 1, DEC, 0, 8'h00); tick();
    chk("dec_ovf", {b0.Z, b0.carry, b0.ovf}, {4'b0111, 1'b0, 1'b1});
    drv0(0, 1, INC, 0, 8'h00); tick();
    chk("inc_ovf", {b0.Z, b0.ovf}, {4'b1000, 1'b1});
    drv0(0, 1, SUB, 0, 8'h01); tick();
    chk("sub_ovf", {b0.Z, b0.carry, b0.ovf}, {4'b0111, 1'b0, 1'b1});
    drv0(1, 0, NOP, 0, 8'h00); tick();
    chk("clear_flags", {b0.Z, b0.carry, b0.ovf}, {4'b0000, 1'b0, 1'b0});
    drv0(0, 0, NOP, 0, 8'h00);

    // Saturation
    drv1(LOAD, 4'b1101); tick();
    drv1(ADD, 4'b0100); tick();
    chk("sat_add", {b1.Z, b1.carry, b1.ovf}, {4'b1111, 1'b1, 1'b0});
    drv1(INC, 4'b0000); tick();
    chk("sat_inc", {b1.Z, b1.carry}, {4'b1111, 1'b1});
    drv1(LOAD, 4'b0010); tick();
    drv1(SUB, 4'b0101); tick();
    chk("sat_sub", {b1.Z, b1.carry}, {4'b0000, 1'b1});
    drv1(DEC, 4'b0000); tick();
    chk("sat_dec", {b1.Z, b1.carry}, {4'b0000, 1'b1});
    drv1(LOAD, 4'b0011); tick();
    drv1(ADD, 4'b0100); tick();
    chk("sat_no_clip", {b1.Z, b1.carry}, {4'b0111, 1'b0});
    b1.en = 1'b0;

    // Wide shifts
    b2.en = 1'b1; b2.op = LOAD; b2.sel = 2'd3; b2.din = 32'h8100_0000; tick();
    chk("wide_load_ch3", b2.Z, 8'h81);
    b2.op = SHL; tick();
    chk("shl", {b2.Z, b2.carry, b2.ovf}, {8'h02, 1'b1, 1'b0});
    b2.op = SHR; tick();
    chk("shr_1", {b2.Z, b2.carry}, {8'h01, 1'b0});
    tick();
    chk("shr_0", {b2.Z, b2.carry, b2.zero}, {8'h00, 1'b1, 1'b1});
    b2.en = 1'b0;

    // Select beyond the last channel reads as zero
    b3.en = 1'b1; b3.op = LOAD; b3.sel = 2'd2; b3.din = 12'h9AB; tick();
    chk("ch3_load_2", b3.Z, 4'h9);
    b3.sel = 2'd3; tick();
    chk("sel_oob", {b3.Z, b3.zero}, {4'h0, 1'b1});
    b3.en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
